ul_decompress_bit: RTL and testbench



---
 rtl/ul_bfp_pkg.sv | 35 +++
 rtl/ul_bfp_expand.sv | 26 ++
 rtl/ul_decompress_bit.sv | 146 ++++++++++++++
 tb/tb_ul_decompress_bit.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/ul_bfp_pkg.sv
// rtl/ul_bfp_pkg.sv - shared constants and types for the uplink block-floating-point path
`timescale 1ns/1ps
package ul_bfp_pkg;

  localparam int NUM_DEFAULT     = 7;
  localparam int BLK_LEN_DEFAULT = 24;

  // Largest exponent the compressor emits (9 is its small-signal code)
  localparam logic [3:0] SHIFT_MAX = 4'd9;

  // Bit positions inside o_err
  localparam int ERR_SHIFT_RANGE = 0;
  localparam int ERR_SHIFT_CHG   = 1;
  localparam int ERR_FRAME       = 2;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_IN_BLK = 1'b1
  } blk_state_e;

  // Everything that travels alongside the data through the 3-stage pipeline
  typedef struct packed {
    logic       sel;
    logic       sop;
    logic       eop;
    logic       vld;
    logic [6:0] slot_idx;
    logic [3:0] symb_idx;
    logic [8:0] prb_idx;
    logic [3:0] ch_type;
    logic [7:0] info;
    logic [2:0] err;
  } bfp_side_t;

endpackage

// File: rtl/ul_bfp_expand.sv
// rtl/ul_bfp_expand.sv - expands one Num-bit mantissa to a 16-bit sample, registered
`timescale 1ns/1ps
module ul_bfp_expand #(
  parameter int Num = 7
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [Num-1:0] code,
  input  logic [3:0]     shift,
  output logic [15:0]    dout
);

  // Mantissa placed in the top bits; low bits are zero, so no rounding happens
  logic signed [15:0] aligned;
  assign aligned = {code, {(16 - Num){1'b0}}};

  // Arithmetic shift right by the block exponent restores the original scale
  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= '0;
    end else begin
      dout <= aligned >>> shift;
    end
  end

endmodule

// File: rtl/ul_decompress_bit.sv
// rtl/ul_decompress_bit.sv - block-floating-point IQ decompressor with framing/exponent checks
`timescale 1ns/1ps
module ul_decompress_bit
  import ul_bfp_pkg::*;
#(
  parameter int Num     = NUM_DEFAULT,
  parameter int BLK_LEN = BLK_LEN_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_sel,
  input  logic             i_sop,
  input  logic             i_eop,
  input  logic             i_vld,
  input  logic [2*Num-1:0] i_din,
  input  logic [3:0]       i_shift,
  input  logic [6:0]       i_slot_idx,
  input  logic [3:0]       i_symb_idx,
  input  logic [8:0]       i_prb_idx,
  input  logic [3:0]       i_ch_type,
  input  logic [7:0]       i_info,
  output logic             o_sel,
  output logic             o_sop,
  output logic             o_eop,
  output logic             o_vld,
  output logic [31:0]      o_dout,
  output logic [6:0]       o_slot_idx,
  output logic [3:0]       o_symb_idx,
  output logic [8:0]       o_prb_idx,
  output logic [3:0]       o_type,
  output logic [7:0]       o_info,
  output logic [2:0]       o_err
);

  blk_state_e     state;
  logic [4:0]     cnt;
  logic [3:0]     held_exp;

  logic           accept;
  logic [3:0]     exp_eff;
  logic [4:0]     cnt_cur;
  logic [2:0]     err_n;
  logic [Num-1:0] code_i_n;
  logic [Num-1:0] code_q_n;

  logic [Num-1:0] s1_code_i;
  logic [Num-1:0] s1_code_q;
  logic [3:0]     s1_shift;
  bfp_side_t      side_s1;
  bfp_side_t      side_s2;
  bfp_side_t      side_s3;
  logic [15:0]    s2_i;
  logic [15:0]    s2_q;

  // Classify the incoming sample against the framing state and held exponent
  always_comb begin
    accept   = i_vld && (i_sop || (state == ST_IN_BLK));
    exp_eff  = (i_vld && i_sop) ? i_shift : held_exp;
    cnt_cur  = i_sop ? 5'd1 : ((cnt == 5'd31) ? cnt : cnt + 5'd1);
    err_n    = '0;
    if (i_vld) begin
      if (exp_eff > SHIFT_MAX) err_n[ERR_SHIFT_RANGE] = 1'b1;
      if ((state == ST_IN_BLK) && !i_sop && (i_shift != held_exp)) err_n[ERR_SHIFT_CHG] = 1'b1;
      if ((state == ST_IN_BLK) && i_sop) err_n[ERR_FRAME] = 1'b1;
      if ((state == ST_IDLE) && !i_sop) err_n[ERR_FRAME] = 1'b1;
      if (accept && i_eop && (cnt_cur != 5'(BLK_LEN))) err_n[ERR_FRAME] = 1'b1;
    end
    // Orphan samples, idle cycles and out-of-range exponents all expand to zero
    code_i_n = '0;
    code_q_n = '0;
    if (accept && !err_n[ERR_SHIFT_RANGE]) begin
      code_i_n = i_din[2*Num-1:Num];
      code_q_n = i_din[Num-1:0];
    end
  end

  // Stage 1: framing FSM, counter, exponent capture and sample registration
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      held_exp  <= '0;
      s1_code_i <= '0;
      s1_code_q <= '0;
      s1_shift  <= '0;
      side_s1   <= '0;
    end else begin
      if (i_vld && i_sop) begin
        held_exp <= i_shift;
        cnt      <= cnt_cur;
        state    <= i_eop ? ST_IDLE : ST_IN_BLK;
      end else if (i_vld && (state == ST_IN_BLK)) begin
        cnt <= cnt_cur;
        if (i_eop) state <= ST_IDLE;
      end
      s1_code_i <= code_i_n;
      s1_code_q <= code_q_n;
      s1_shift  <= exp_eff;
      side_s1   <= '{sel: i_sel, sop: i_sop, eop: i_eop, vld: i_vld,
                     slot_idx: i_slot_idx, symb_idx: i_symb_idx, prb_idx: i_prb_idx,
                     ch_type: i_ch_type, info: i_info, err: err_n};
    end
  end

  // Stage 2: expansion of each component
  ul_bfp_expand #(.Num(Num)) u_expand_i (
    .clk   (clk),
    .rst   (rst),
    .code  (s1_code_i),
    .shift (s1_shift),
    .dout  (s2_i)
  );

  ul_bfp_expand #(.Num(Num)) u_expand_q (
    .clk   (clk),
    .rst   (rst),
    .code  (s1_code_q),
    .shift (s1_shift),
    .dout  (s2_q)
  );

  // Stages 2 and 3: sideband delay and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      side_s2 <= '0;
      side_s3 <= '0;
      o_dout  <= '0;
    end else begin
      side_s2 <= side_s1;
      side_s3 <= side_s2;
      o_dout  <= {s2_i, s2_q};
    end
  end

  assign o_sel      = side_s3.sel;
  assign o_sop      = side_s3.sop;
  assign o_eop      = side_s3.eop;
  assign o_vld      = side_s3.vld;
  assign o_slot_idx = side_s3.slot_idx;
  assign o_symb_idx = side_s3.symb_idx;
  assign o_prb_idx  = side_s3.prb_idx;
  assign o_type     = side_s3.ch_type;
  assign o_info     = side_s3.info;
  assign o_err      = side_s3.err;

endmodule

// File: tb/tb_ul_decompress_bit.sv
// tb/tb_ul_decompress_bit.sv - directed self-checking bench for ul_decompress_bit
`timescale 1ns/1ps
module tb_ul_decompress_bit;

  localparam int NUM = 7;

  logic            clk = 1'b0;
  logic            rst;
  logic            i_sel, i_sop, i_eop, i_vld;
  logic [2*NUM-1:0] i_din;
  logic [3:0]      i_shift;
  logic [6:0]      i_slot_idx;
  logic [3:0]      i_symb_idx;
  logic [8:0]      i_prb_idx;
  logic [3:0]      i_ch_type;
  logic [7:0]      i_info;
  logic            o_sel, o_sop, o_eop, o_vld;
  logic [31:0]     o_dout;
  logic [6:0]      o_slot_idx;
  logic [3:0]      o_symb_idx;
  logic [8:0]      o_prb_idx;
  logic [3:0]      o_type;
  logic [7:0]      o_info;
  logic [2:0]      o_err;

  typedef struct {
    logic        vld;
    logic        sop;
    logic        eop;
    logic [31:0] dout;
    logic [2:0]  err;
    logic [32:0] side;
  } exp_t;

  exp_t expq[$];
  int   checks  = 0;
  int   errors  = 0;
  int   step_no = 0;

  always #5 clk = ~clk;

  ul_decompress_bit #(.Num(NUM), .BLK_LEN(24)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_sel      (i_sel),
    .i_sop      (i_sop),
    .i_eop      (i_eop),
    .i_vld      (i_vld),
    .i_din      (i_din),
    .i_shift    (i_shift),
    .i_slot_idx (i_slot_idx),
    .i_symb_idx (i_symb_idx),
    .i_prb_idx  (i_prb_idx),
    .i_ch_type  (i_ch_type),
    .i_info     (i_info),
    .o_sel      (o_sel),
    .o_sop      (o_sop),
    .o_eop      (o_eop),
    .o_vld      (o_vld),
    .o_dout     (o_dout),
    .o_slot_idx (o_slot_idx),
    .o_symb_idx (o_symb_idx),
    .o_prb_idx  (o_prb_idx),
    .o_type     (o_type),
    .o_info     (o_info),
    .o_err      (o_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
    end
  endtask

  task automatic push_zero();
    exp_t z;
    z.vld = 1'b0; z.sop = 1'b0; z.eop = 1'b0;
    z.dout = '0; z.err = '0; z.side = '0;
    expq.push_back(z);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    i_vld = 1'b1; i_sop = 1'b0; i_eop = 1'b1; i_sel = 1'b1;
    i_din = 14'h3FFF; i_shift = 4'd5;
    i_slot_idx = 7'h7F; i_symb_idx = 4'hF; i_prb_idx = 9'h1FF; i_ch_type = 4'hF; i_info = 8'hFF;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      check("rst_dout", 64'(o_dout), 64'd0);
      check("rst_err", 64'(o_err), 64'd0);
      check("rst_frame", 64'({o_sel, o_sop, o_eop, o_vld}), 64'd0);
      check("rst_side", 64'({o_slot_idx, o_symb_idx, o_prb_idx, o_type, o_info}), 64'd0);
    end
    rst = 1'b0;
    i_vld = 1'b0; i_sop = 1'b0; i_eop = 1'b0;
    expq.delete();
    push_zero();
    push_zero();
  endtask

  task automatic step(input logic vld, input logic sop, input logic eop,
                      input logic [6:0] ci, input logic [6:0] cq, input logic [3:0] sh,
                      input logic [31:0] edout, input logic [2:0] eerr);
    exp_t       e;
    logic [9:0] s;
    step_no++;
    s = step_no[9:0];
    i_vld = vld; i_sop = sop; i_eop = eop;
    i_din = {ci, cq}; i_shift = sh;
    i_sel = s[0]; i_slot_idx = s[6:0]; i_symb_idx = s[3:0]; i_prb_idx = s[8:0];
    i_ch_type = s[7:4]; i_info = s[7:0] ^ 8'hA5;
    e.vld = vld; e.sop = sop; e.eop = eop; e.dout = edout; e.err = eerr;
    e.side = {i_sel, i_slot_idx, i_symb_idx, i_prb_idx, i_ch_type, i_info};
    expq.push_back(e);
    @(posedge clk); #1;
    if (expq.size() == 3) begin
      e = expq.pop_front();
      check("dout", 64'(o_dout), 64'(e.dout));
      check("err", 64'(o_err), 64'(e.err));
      check("frame", 64'({o_sop, o_eop, o_vld}), 64'({e.sop, e.eop, e.vld}));
      check("side", 64'({o_sel, o_slot_idx, o_symb_idx, o_prb_idx, o_type, o_info}), 64'(e.side));
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 7'h00, 7'h00, 4'd0, 32'h0, 3'b000);
  endtask

  initial begin
    rst = 1'b1;
    i_vld = 1'b0; i_sop = 1'b0; i_eop = 1'b0; i_sel = 1'b0;
    i_din = '0; i_shift = '0;
    i_slot_idx = '0; i_symb_idx = '0; i_prb_idx = '0; i_ch_type = '0; i_info = '0;
    do_reset(2);
    idle();
    idle();

    // Shift 2 block with a gap cycle in the middle
    for (int k = 0; k < 24; k++) begin
      if (k == 12) idle();
      if (k == 0) step(1'b1, 1'b1, 1'b0, 7'h3F, 7'h40, 4'd2, 32'h1F80_E000, 3'b000);
      else        step(1'b1, 1'b0, k == 23, 7'h01, 7'h7F, 4'd2, 32'h0080_FF80, 3'b000);
    end

    // Shift 9 (small-signal code)
    for (int k = 0; k < 24; k++) begin
      if (k == 1) step(1'b1, 1'b0, 1'b0, 7'h40, 7'h3F, 4'd9, 32'hFFC0_003F, 3'b000);
      else        step(1'b1, k == 0, k == 23, 7'h01, 7'h00, 4'd9, 32'h0001_0000, 3'b000);
    end

    // Shift 12 is out of range: zero data, range flag on every sample
    for (int k = 0; k < 24; k++)
      step(1'b1, k == 0, k == 23, 7'h3F, 7'h40, 4'd12, 32'h0, 3'b001);

    // Exponent change on sample 5 only; data keeps the held exponent
    for (int k = 0; k < 24; k++) begin
      if (k == 5) step(1'b1, 1'b0, 1'b0, 7'h3F, 7'h40, 4'd3, 32'h1F80_E000, 3'b010);
      else        step(1'b1, k == 0, k == 23, 7'h3F, 7'h40, 4'd2, 32'h1F80_E000, 3'b000);
    end

    // Short block: eop on sample 20
    for (int k = 0; k < 20; k++)
      step(1'b1, k == 0, k == 19, 7'h3F, 7'h40, 4'd2, 32'h1F80_E000, (k == 19) ? 3'b100 : 3'b000);

    // Orphan sample without sop
    step(1'b1, 1'b0, 1'b0, 7'h3F, 7'h40, 4'd2, 32'h0, 3'b100);

    // sop inside a block restarts it with a new exponent
    for (int k = 0; k < 3; k++)
      step(1'b1, k == 0, 1'b0, 7'h3F, 7'h40, 4'd2, 32'h1F80_E000, 3'b000);
    for (int k = 0; k < 24; k++)
      step(1'b1, k == 0, k == 23, 7'h3F, 7'h40, 4'd0, 32'h7E00_8000, (k == 0) ? 3'b100 : 3'b000);

    // Oversize block: counter saturates, eop on sample 33 flags
    for (int k = 0; k < 33; k++)
      step(1'b1, k == 0, k == 32, 7'h01, 7'h7F, 4'd0, 32'h0200_FE00, (k == 32) ? 3'b100 : 3'b000);

    // Reset in the middle of a block
    for (int k = 0; k < 5; k++)
      step(1'b1, k == 0, 1'b0, 7'h3F, 7'h40, 4'd2, 32'h1F80_E000, 3'b000);
    do_reset(1);
    idle();
    idle();
    step(1'b1, 1'b0, 1'b0, 7'h3F, 7'h40, 4'd1, 32'h0, 3'b100);
    for (int k = 0; k < 24; k++)
      step(1'b1, k == 0, k == 23, 7'h3F, 7'h40, 4'd1, 32'h3F00_C000, 3'b000);

    idle();
    idle();
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
